// File: rtl/bp_dir_ctrl_if.sv
// Decode/execute-facing signal bundle of the branch-direction predictor.
// The master side is the pipeline; the slave side is the predictor.
interface bp_dir_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             LookupD;
  logic [31:0]      PCD;
  logic             PredTakenD;
  logic             StallD;
  logic             ResolveE;
  logic             TakenE;
  logic             MispredE;
  logic             FlushQ;
  logic             QEmpty;
  logic             ResolveErr;
  logic [CNT_W-1:0] PredCnt;
  logic [CNT_W-1:0] MispredCnt;

  modport master (
    output LookupD, PCD, ResolveE, TakenE, FlushQ,
    input  PredTakenD, StallD, MispredE, QEmpty, ResolveErr, PredCnt, MispredCnt
  );

  modport slave (
    input  LookupD, PCD, ResolveE, TakenE, FlushQ,
    output PredTakenD, StallD, MispredE, QEmpty, ResolveErr, PredCnt, MispredCnt
  );
endinterface

// File: rtl/bp_dir_ctrl.sv
// Gshare-indexed 2-bit counter direction predictor with an in-order in-flight
// prediction queue, speculative/committed history and resolve statistics.
module bp_dir_ctrl #(
  parameter int unsigned IDX_BITS = 4,
  parameter int unsigned GHR_BITS = 4,
  parameter int unsigned QDEPTH   = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  bp_dir_ctrl_if.slave bus
);

  localparam int unsigned TBL_SIZE = 1 << IDX_BITS;
  localparam int unsigned PTR_W    = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned OCC_W    = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [IDX_BITS-1:0] idx;
    logic                pred;
    logic [GHR_BITS-1:0] ghr;
  } qent_t;

  logic [1:0]          tbl [TBL_SIZE];
  qent_t               q   [QDEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [OCC_W-1:0]    occ;
  logic [GHR_BITS-1:0] spec_ghr, comm_ghr;
  logic [CNT_W-1:0]    pred_cnt, mis_cnt;
  logic                resolve_err;

  logic [IDX_BITS-1:0] idx;
  logic                pred_raw;
  logic                q_empty, q_full;
  logic                do_resolve, mispred, stall, push, clear_q;
  qent_t               head;
  logic [1:0]          ctr_cur, ctr_nxt;
  logic [GHR_BITS-1:0] comm_nxt;

  // Lookup path and queue control
  always_comb begin
    idx        = bus.PCD[IDX_BITS+1:2] ^ IDX_BITS'(spec_ghr);
    pred_raw   = tbl[idx][1];
    q_empty    = (occ == '0);
    q_full     = (occ == OCC_W'(QDEPTH));
    head       = q[rd_ptr];
    do_resolve = bus.ResolveE && !q_empty && !reset;
    mispred    = do_resolve && (head.pred != bus.TakenE);
    // A correct same-cycle pop frees a slot, so a push at full still goes in
    stall      = q_full && !(bus.ResolveE && !mispred) && !reset;
    push       = bus.LookupD && !stall && !mispred && !bus.FlushQ && !reset;
    clear_q    = mispred || bus.FlushQ;
    comm_nxt   = do_resolve ? {comm_ghr[GHR_BITS-2:0], bus.TakenE} : comm_ghr;
  end

  // Saturating counter step for the resolving entry
  always_comb begin
    ctr_cur = tbl[head.idx];
    ctr_nxt = ctr_cur;
    if (bus.TakenE) begin
      if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'd1;
    end
  end

  assign bus.PredTakenD = bus.LookupD && pred_raw && !reset;
  assign bus.StallD     = stall;
  assign bus.MispredE   = mispred;
  assign bus.QEmpty     = q_empty;
  assign bus.ResolveErr = resolve_err;
  assign bus.PredCnt    = pred_cnt;
  assign bus.MispredCnt = mis_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < TBL_SIZE; i++) tbl[IDX_BITS'(i)] <= 2'b00;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occ         <= '0;
      spec_ghr    <= '0;
      comm_ghr    <= '0;
      pred_cnt    <= '0;
      mis_cnt     <= '0;
      resolve_err <= 1'b0;
    end else begin
      if (do_resolve) begin
        tbl[head.idx] <= ctr_nxt;
        comm_ghr      <= comm_nxt;
        if (pred_cnt != '1) pred_cnt <= pred_cnt + CNT_W'(1);
        if (mispred && (mis_cnt != '1)) mis_cnt <= mis_cnt + CNT_W'(1);
      end
      if (bus.ResolveE && q_empty) resolve_err <= 1'b1;

      // Mispredict or flush: younger entries are wrong-path, restart from committed history
      if (clear_q) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        occ      <= '0;
        spec_ghr <= comm_nxt;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + PTR_W'(1);
          spec_ghr <= {spec_ghr[GHR_BITS-2:0], pred_raw};
        end
        if (do_resolve) rd_ptr <= rd_ptr + PTR_W'(1);
        occ <= occ + OCC_W'(push) - OCC_W'(do_resolve);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) q[wr_ptr] <= '{idx: idx, pred: pred_raw, ghr: spec_ghr};
  end

  // Every older branch resolved correctly, so the head's history must be the committed one
  always_ff @(posedge clk) begin
    if (!reset && do_resolve) assert (head.ghr == comm_ghr);
  end

  logic unused_ok;
  assign unused_ok = ^{bus.PCD[31:IDX_BITS+2], bus.PCD[1:0], head.ghr};

endmodule

// File: tb/tb_bp_dir_ctrl.sv
// Scoreboard bench for bp_dir_ctrl: stimulus pushes model expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_bp_dir_ctrl;
  localparam int IDX = 4;
  localparam int GHR = 4;
  localparam int QD  = 4;
  localparam int CW  = 16;
  localparam int TMASK = (1 << IDX) - 1;
  localparam int GMASK = (1 << GHR) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bp_dir_ctrl_if #(.CNT_W(CW)) bus();

  bp_dir_ctrl #(.IDX_BITS(IDX), .GHR_BITS(GHR), .QDEPTH(QD), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct { int idx; bit pred; } ment_t;
  typedef struct { bit pred; bit stall; bit mis; bit empty; bit err; int pcnt; int mcnt; } exp_t;

  int     mtbl [1 << IDX];
  ment_t  mq[$];
  int     spec, comm, pcnt, mcnt;
  bit     err;
  exp_t   expq[$];
  int     checks, errors;

  function automatic void model_reset();
    foreach (mtbl[i]) mtbl[i] = 0;
    mq.delete();
    spec = 0; comm = 0; pcnt = 0; mcnt = 0; err = 0;
  endfunction

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // One bus cycle: drive, record expected outputs, advance the reference model
  task automatic cyc(input bit lk, input logic [31:0] pc, input bit rs, input bit tk, input bit fl);
    exp_t  e;
    ment_t h;
    int    idx;
    bit    pr, resolving, mis, stall, push;
    bus.LookupD = lk; bus.PCD = pc; bus.ResolveE = rs; bus.TakenE = tk; bus.FlushQ = fl;
    idx       = ((pc >> 2) & TMASK) ^ spec;
    pr        = lk && (mtbl[idx] >= 2);
    resolving = rs && (mq.size() > 0);
    mis       = resolving && (mq[0].pred != tk);
    stall     = (mq.size() == QD) && !(rs && !mis);
    e = '{pred: pr, stall: stall, mis: mis, empty: (mq.size() == 0), err: err, pcnt: pcnt, mcnt: mcnt};
    expq.push_back(e);
    push = lk && !stall && !mis && !fl;
    if (resolving) begin
      h = mq.pop_front();
      if (tk) mtbl[h.idx] = (mtbl[h.idx] == 3) ? 3 : mtbl[h.idx] + 1;
      else    mtbl[h.idx] = (mtbl[h.idx] == 0) ? 0 : mtbl[h.idx] - 1;
      comm = ((comm << 1) | int'(tk)) & GMASK;
      if (pcnt < (1 << CW) - 1) pcnt++;
      if (mis && mcnt < (1 << CW) - 1) mcnt++;
    end else if (rs) begin
      err = 1;
    end
    if (mis || fl) begin
      mq.delete();
      spec = comm;
    end else if (push) begin
      mq.push_back('{idx: idx, pred: pr});
      spec = ((spec << 1) | int'(pr)) & GMASK;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.LookupD = 1'($urandom); bus.PCD = $urandom; bus.ResolveE = 1'($urandom);
    bus.TakenE = 1'($urandom); bus.FlushQ = 1'($urandom);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [31:0] pc_for_idx(int target);
    return 32'(((target ^ spec) & TMASK) << 2) | 32'h1000_0000;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("PredTakenD", 32'(bus.PredTakenD), 32'(e.pred));
      chk("StallD",     32'(bus.StallD),     32'(e.stall));
      chk("MispredE",   32'(bus.MispredE),   32'(e.mis));
      chk("QEmpty",     32'(bus.QEmpty),     32'(e.empty));
      chk("ResolveErr", 32'(bus.ResolveErr), 32'(e.err));
      chk("PredCnt",    32'(bus.PredCnt),    32'(e.pcnt));
      chk("MispredCnt", 32'(bus.MispredCnt), 32'(e.mcnt));
    end
  end

  initial begin
    int sel, wait_cyc;
    bit lk, rs, tk, fl;
    checks = 0; errors = 0;
    reset = 1'b1;
    bus.LookupD = 0; bus.PCD = '0; bus.ResolveE = 0; bus.TakenE = 0; bus.FlushQ = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();

    // Reset state, then first lookup/mispredicted resolve
    cyc(0, 0, 0, 0, 0);
    cyc(1, 32'h10, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);

    // Single entry walked up to saturation and back down, one branch in flight at a time
    for (int i = 0; i < 4; i++) begin
      cyc(1, pc_for_idx(4), 0, 0, 0);
      cyc(0, 0, 1, 1, 0);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1, pc_for_idx(4), 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
    end
    cyc(1, pc_for_idx(4), 0, 0, 0);
    cyc(0, 0, 1, 0, 0);

    // Fill to full, push with a correct pop at full, lookup alone at full
    for (int i = 0; i < 4; i++) cyc(1, $urandom, 0, 0, 0);
    cyc(1, $urandom, 1, mq[0].pred, 0);
    cyc(1, $urandom, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Three in flight, head mispredicts with a same-cycle lookup
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, $urandom, 0, 0, 0);
    cyc(1, $urandom, 1, !mq[0].pred, 0);
    cyc(1, $urandom, 0, 0, 0);

    // External flush with two in flight
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) cyc(1, $urandom, 0, 0, 0);
    cyc(1, $urandom, 0, 0, 1);
    cyc(1, $urandom, 1, 1, 0);

    // Resolve on empty queue, sticky error
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Reset with a full queue
    for (int i = 0; i < 4; i++) cyc(1, $urandom, 0, 0, 0);
    do_reset();
    cyc(0, 0, 0, 0, 0);

    // Random traffic with PC-dependent bias so counters learn
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 15);
      lk  = ($urandom_range(0, 99) < 60);
      rs  = ($urandom_range(0, 99) < 45);
      fl  = ($urandom_range(0, 99) < 4);
      tk  = ($urandom_range(0, 99) < sel * 6 + 5);
      if ($urandom_range(0, 999) < 2) do_reset();
      else cyc(lk, {$urandom_range(0, 255), 18'h0, 4'(sel), 2'b00}, rs, tk, fl);
    end

    bus.LookupD = 0; bus.ResolveE = 0; bus.FlushQ = 0;
    wait_cyc = 0;
    while (expq.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    checks++;
    if (expq.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
